// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
//   RegAddrW  : GPR address width
//   StallW    : per-stage stall vector width, [0]pc [1]if [2]id [3]ex [4]mem [5]wb
//   Stall*    : stall vector patterns (hold nothing / hold up to ID / hold up to EX)
//   McKind*   : multi-cycle operation kind encodings
//   state_e   : controller FSM states
package pipe_hazard_ctrl_pkg;

  localparam int unsigned RegAddrW = 5;
  localparam int unsigned StallW   = 6;

  localparam logic [StallW-1:0] StallNone = 6'b000000;
  localparam logic [StallW-1:0] StallId   = 6'b000111;
  localparam logic [StallW-1:0] StallEx   = 6'b001111;

  localparam logic McKindMul = 1'b0;
  localparam logic McKindDiv = 1'b1;

  typedef enum logic {
    StRun  = 1'b0,
    StMcyc = 1'b1
  } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_mc_countdown.sv
// Multi-cycle operation countdown: load, decrement, and last-cycle flag.
// Ports:
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset, clears the count
//   load_i     : load load_val_i (highest priority after clr_i)
//   load_val_i : value loaded on load_i
//   dec_i      : decrement by one (holds at zero)
//   clr_i      : clear count to zero
//   cnt_o      : current count
//   last_o     : count equals one (final cycle of the operation)
module pipe_hazard_ctrl_mc_countdown #(
  parameter int unsigned CntW = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  input  logic            clr_i,
  output logic [CntW-1:0] cnt_o,
  output logic            last_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CntW'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS32 CPU: load-use hazard
// detection, EX hold for multi-cycle MULT/DIV, and exception flush.
// Priority: exception flush > multi-cycle > load-use.
// Optional feature macro: STALL_STATS_EN enables a saturating count of cycles
// with any stage stalled on stall_cnt_o; otherwise stall_cnt_o is tied to zero.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   id_re{1,2}_i/raddr{1,2}_i : ID register read ports
//   ex_wreg_i/ex_waddr_i      : EX destination GPR write
//   ex_is_load_i              : EX holds a load
//   ex_mc_start_i/kind_i      : start multi-cycle op (0=MULT, 1=DIV)
//   exc_flush_i               : exception/ERET flush request
//   stall_o                   : per-stage hold vector
//   flush_o                   : clear all pipeline registers
//   mc_done_o                 : one-cycle pulse, EX multi-cycle result valid
//   busy_o                    : multi-cycle op in progress
//   stall_cnt_o               : stall-cycle statistic
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 34,
  parameter int unsigned CNT_W      = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_re1_i,
  input  logic [RegAddrW-1:0] id_raddr1_i,
  input  logic                id_re2_i,
  input  logic [RegAddrW-1:0] id_raddr2_i,
  input  logic                ex_wreg_i,
  input  logic [RegAddrW-1:0] ex_waddr_i,
  input  logic                ex_is_load_i,
  input  logic                ex_mc_start_i,
  input  logic                ex_mc_kind_i,
  input  logic                exc_flush_i,
  output logic [StallW-1:0]   stall_o,
  output logic                flush_o,
  output logic                mc_done_o,
  output logic                busy_o,
  output logic [31:0]         stall_cnt_o
);

  // The start cycle itself is one cycle of occupancy, so load N-1.
  localparam logic [CNT_W-1:0] MulLoad = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DivLoad = CNT_W'(DIV_CYCLES - 1);

  state_e           state_q, state_d;
  logic             cnt_load, cnt_dec, cnt_clr, cnt_last;
  logic [CNT_W-1:0] cnt_load_val, cnt;
  logic             load_use;

  // $0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = ex_is_load_i & ex_wreg_i & (ex_waddr_i != '0) &
                    ((id_re1_i & (id_raddr1_i == ex_waddr_i)) |
                     (id_re2_i & (id_raddr2_i == ex_waddr_i)));

  pipe_hazard_ctrl_mc_countdown #(
    .CntW (CNT_W)
  ) u_mc_countdown (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .dec_i      (cnt_dec),
    .clr_i      (cnt_clr),
    .cnt_o      (cnt),
    .last_o     (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    stall_o      = StallNone;
    flush_o      = 1'b0;
    mc_done_o    = 1'b0;
    busy_o       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = MulLoad;
    cnt_dec      = 1'b0;
    cnt_clr      = 1'b0;
    if (rst) begin
      state_d = StRun;
    end else if (exc_flush_i) begin
      // Aborts any in-flight op without a done pulse.
      flush_o = 1'b1;
      cnt_clr = 1'b1;
      state_d = StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          if (ex_mc_start_i) begin
            stall_o      = StallEx;
            cnt_load     = 1'b1;
            cnt_load_val = (ex_mc_kind_i == McKindDiv) ? DivLoad : MulLoad;
            state_d      = StMcyc;
          end else if (load_use) begin
            stall_o = StallId;
          end
        end
        StMcyc: begin
          // ex_mc_start_i is ignored here: EX re-presents the held instruction.
          busy_o = 1'b1;
          if (cnt_last) begin
            mc_done_o = 1'b1;
            cnt_clr   = 1'b1;
            state_d   = StRun;
          end else begin
            stall_o = StallEx;
            cnt_dec = 1'b1;
          end
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef STALL_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((stall_o != StallNone) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = 32'h0;
`endif

  // Count value is only consumed through last_o; keep it observable for debug.
  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios against fixed
// expected patterns, then randomized traffic against a cycle-level model that
// tracks operation age and length rather than a countdown.
module tb_pipe_hazard_ctrl;

  localparam int MulLen = 3;
  localparam int DivLen = 34;

  logic        clk;
  logic        rst;
  logic        id_re1_i, id_re2_i;
  logic [4:0]  id_raddr1_i, id_raddr2_i;
  logic        ex_wreg_i, ex_is_load_i, ex_mc_start_i, ex_mc_kind_i, exc_flush_i;
  logic [4:0]  ex_waddr_i;
  logic [5:0]  stall_o;
  logic        flush_o, mc_done_o, busy_o;
  logic [31:0] stall_cnt_o;

  int checks = 0;
  int errors = 0;

  pipe_hazard_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .id_re1_i      (id_re1_i),
    .id_raddr1_i   (id_raddr1_i),
    .id_re2_i      (id_re2_i),
    .id_raddr2_i   (id_raddr2_i),
    .ex_wreg_i     (ex_wreg_i),
    .ex_waddr_i    (ex_waddr_i),
    .ex_is_load_i  (ex_is_load_i),
    .ex_mc_start_i (ex_mc_start_i),
    .ex_mc_kind_i  (ex_mc_kind_i),
    .exc_flush_i   (exc_flush_i),
    .stall_o       (stall_o),
    .flush_o       (flush_o),
    .mc_done_o     (mc_done_o),
    .busy_o        (busy_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an op is "in flight" with an age (cycles of EX occupancy
  // so far) and a length; the final cycle is the one where age+1 == length.
  bit          m_in_op = 1'b0;
  int          m_age   = 0;
  int          m_len   = 0;
  logic [31:0] m_stats = 32'h0;
  logic [5:0]  exp_stall;
  logic        exp_flush, exp_done, exp_busy, m_hazard;

  always_comb begin
    m_hazard = ex_is_load_i && ex_wreg_i && (ex_waddr_i != 5'd0) &&
               ((id_re1_i && (id_raddr1_i == ex_waddr_i)) ||
                (id_re2_i && (id_raddr2_i == ex_waddr_i)));
    exp_stall = 6'b000000;
    exp_flush = 1'b0;
    exp_done  = 1'b0;
    exp_busy  = 1'b0;
    if (rst) begin
      exp_stall = 6'b000000;
    end else if (exc_flush_i) begin
      exp_flush = 1'b1;
    end else if (m_in_op) begin
      exp_busy = 1'b1;
      if (m_age + 1 == m_len) exp_done = 1'b1;
      else exp_stall = 6'b001111;
    end else if (ex_mc_start_i) begin
      exp_stall = 6'b001111;
    end else if (m_hazard) begin
      exp_stall = 6'b000111;
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_in_op = 1'b0;
      m_stats = 32'h0;
    end else begin
      if (exp_stall != 6'b0 && m_stats != 32'hFFFF_FFFF) m_stats = m_stats + 32'd1;
      if (exc_flush_i) begin
        m_in_op = 1'b0;
      end else if (m_in_op) begin
        if (m_age + 1 == m_len) m_in_op = 1'b0;
        else m_age = m_age + 1;
      end else if (ex_mc_start_i) begin
        m_in_op = 1'b1;
        m_age   = 1;
        m_len   = ex_mc_kind_i ? DivLen : MulLen;
      end
    end
  end

  function automatic logic [31:0] exp_stat_out(input logic [31:0] v);
`ifdef STALL_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic clk_adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_re1_i = 0; id_raddr1_i = 0; id_re2_i = 0; id_raddr2_i = 0;
    ex_wreg_i = 0; ex_waddr_i = 0; ex_is_load_i = 0;
    ex_mc_start_i = 0; ex_mc_kind_i = 0; exc_flush_i = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk_adv();
    clk_adv();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    ex_mc_start_i = 1'b1;
    exc_flush_i   = 1'b1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({stall_o, flush_o, mc_done_o, busy_o} !== 9'b0) begin
        errors++;
        $display("FAIL reset_outputs: got %b,%b,%b,%b want all zero",
                 stall_o, flush_o, mc_done_o, busy_o);
      end
      clk_adv();
    end
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall_o, flush_o, mc_done_o, busy_o} !== 9'b0 || stall_cnt_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: got %b,%b,%b,%b cnt=%0d want all zero",
               stall_o, flush_o, mc_done_o, busy_o, stall_cnt_o);
    end
    clk_adv();
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = 5'd5;
    id_re1_i = 1; id_raddr1_i = 5'd5;
    @(negedge clk);
    checks++;
    if (stall_o !== 6'b000111) begin
      errors++;
      $display("FAIL load_use_re1: stall_o=%b want 000111", stall_o);
    end
    clk_adv();
    // Bubble now in EX: the load has moved on.
    ex_is_load_i = 0; ex_wreg_i = 0; ex_waddr_i = 0;
    @(negedge clk);
    checks++;
    if (stall_o !== 6'b000000) begin
      errors++;
      $display("FAIL load_use_one_cycle: stall_o=%b want 000000", stall_o);
    end
    clk_adv();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = 5'd0; id_raddr1_i = 5'd0;
    @(negedge clk);
    checks++;
    if (stall_o !== 6'b000000) begin
      errors++;
      $display("FAIL load_use_zero_reg: stall_o=%b want 000000", stall_o);
    end
    clk_adv();
    id_re1_i = 0; ex_waddr_i = 5'd17; id_re2_i = 1; id_raddr2_i = 5'd17;
    @(negedge clk);
    checks++;
    if (stall_o !== 6'b000111) begin
      errors++;
      $display("FAIL load_use_re2: stall_o=%b want 000111", stall_o);
    end
    clk_adv();
    idle_inputs();
  endtask

  task automatic test_mult();
    logic [8:0] want [4];
    want[0] = {6'b001111, 1'b0, 1'b0, 1'b0};
    want[1] = {6'b001111, 1'b0, 1'b0, 1'b1};
    want[2] = {6'b000000, 1'b0, 1'b1, 1'b1};
    want[3] = {6'b000000, 1'b0, 1'b0, 1'b0};
    idle_inputs();
    ex_mc_start_i = 1; ex_mc_kind_i = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({stall_o, flush_o, mc_done_o, busy_o} !== want[c]) begin
        errors++;
        $display("FAIL mult_cycle%0d: got %b want %b", c + 1,
                 {stall_o, flush_o, mc_done_o, busy_o}, want[c]);
      end
      clk_adv();
      ex_mc_start_i = 0;
    end
  endtask

  task automatic test_div();
    int  stalled = 0;
    bit  done_seen = 0;
    idle_inputs();
    ex_mc_start_i = 1; ex_mc_kind_i = 1;
    for (int c = 0; c < 60 && !done_seen; c++) begin
      @(negedge clk);
      if (mc_done_o) begin
        done_seen = 1;
        ex_mc_start_i = 0;
        checks++;
        if (stall_o !== 6'b0 || busy_o !== 1'b1) begin
          errors++;
          $display("FAIL div_done_cycle: stall_o=%b busy_o=%b want 000000,1",
                   stall_o, busy_o);
        end
      end else if (stall_o == 6'b001111) begin
        stalled++;
      end
      clk_adv();
    end
    checks++;
    if (!done_seen || stalled != DivLen - 1) begin
      errors++;
      $display("FAIL div_stall_count: done=%0d stalled=%0d want done=1 stalled=%0d",
               done_seen, stalled, DivLen - 1);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    bit done_seen = 0;
    idle_inputs();
    ex_mc_start_i = 1; ex_mc_kind_i = 1;
    for (int c = 1; c < 10; c++) begin
      clk_adv();
      ex_mc_start_i = 0;
    end
    exc_flush_i = 1;
    @(negedge clk);
    checks++;
    if (flush_o !== 1'b1 || stall_o !== 6'b0 || mc_done_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_div10: flush=%b stall=%b done=%b want 1,000000,0",
               flush_o, stall_o, mc_done_o);
    end
    clk_adv();
    exc_flush_i = 0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || flush_o !== 1'b0 || stall_o !== 6'b0) begin
      errors++;
      $display("FAIL flush_after: busy=%b flush=%b stall=%b want 0,0,000000",
               busy_o, flush_o, stall_o);
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mc_done_o) done_seen = 1;
      clk_adv();
    end
    checks++;
    if (done_seen) begin
      errors++;
      $display("FAIL flush_no_done: mc_done_o seen=1 want 0");
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    ex_mc_start_i = 1; ex_mc_kind_i = 0;
    clk_adv();
    ex_mc_start_i = 0;
    rst = 1;
    @(negedge clk);
    checks++;
    if ({stall_o, flush_o, mc_done_o, busy_o} !== 9'b0) begin
      errors++;
      $display("FAIL rst_mid_mult: got %b want 000000000",
               {stall_o, flush_o, mc_done_o, busy_o});
    end
    clk_adv();
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({stall_o, flush_o, mc_done_o, busy_o} !== 9'b0 || stall_cnt_o !== 32'h0) begin
        errors++;
        $display("FAIL rst_mid_after%0d: got %b cnt=%0d want zeros", c,
                 {stall_o, flush_o, mc_done_o, busy_o}, stall_cnt_o);
      end
      clk_adv();
    end
  endtask

  task automatic test_stats();
    logic [31:0] want;
    idle_inputs();
    do_reset();
    ex_mc_start_i = 1; ex_mc_kind_i = 0;
    clk_adv();
    ex_mc_start_i = 0;
    clk_adv();
    clk_adv();
    ex_is_load_i = 1; ex_wreg_i = 1; ex_waddr_i = 5'd9; id_re2_i = 1; id_raddr2_i = 5'd9;
    clk_adv();
    idle_inputs();
    clk_adv();
    @(negedge clk);
`ifdef STALL_STATS_EN
    want = 32'd3;
`else
    want = 32'd0;
`endif
    checks++;
    if (stall_cnt_o !== want) begin
      errors++;
      $display("FAIL stats_mult_loaduse: stall_cnt_o=%0d want %0d", stall_cnt_o, want);
    end
    clk_adv();
  endtask

  task automatic test_random();
    int bad = 0;
    idle_inputs();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 299) == 0);
      exc_flush_i   = ($urandom_range(0, 39) == 0);
      ex_mc_start_i = ($urandom_range(0, 7) == 0);
      ex_mc_kind_i  = ($urandom_range(0, 3) == 0);
      ex_is_load_i  = $urandom_range(0, 1);
      ex_wreg_i     = ($urandom_range(0, 3) != 0);
      ex_waddr_i    = 5'($urandom_range(0, 3));
      id_re1_i      = $urandom_range(0, 1);
      id_re2_i      = $urandom_range(0, 1);
      id_raddr1_i   = 5'($urandom_range(0, 3));
      id_raddr2_i   = 5'($urandom_range(0, 3));
      @(negedge clk);
      checks++;
      if ({stall_o, flush_o, mc_done_o, busy_o} !==
          {exp_stall, exp_flush, exp_done, exp_busy}) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d: got %b want %b", c,
                   {stall_o, flush_o, mc_done_o, busy_o},
                   {exp_stall, exp_flush, exp_done, exp_busy});
      end
      if (!rst) begin
        checks++;
        if (stall_cnt_o !== exp_stat_out(m_stats)) begin
          errors++;
          bad++;
          if (bad <= 10)
            $display("FAIL random_stats%0d: got %0d want %0d", c, stall_cnt_o,
                     exp_stat_out(m_stats));
        end
      end
      clk_adv();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_mult();
    test_div();
    test_flush();
    test_reset_mid();
    test_stats();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
